// File: rtl/apu_audio_dac.sv
// ---------------------------------------------------------------------------
// apu_audio_dac
//
// Audio output stage downstream of the APU mixer. Each sample strobe adds the
// mixer sample into a box-car accumulator. Every N = 2^DECIM_LOG2 strobes the
// truncated average is produced. That average goes to two places:
//   - a one-entry ready/valid buffer for a codec/I2S serializer, with a
//     sticky overrun flag that records a lost sample;
//   - a first-order delta-sigma modulator. It runs every clock and produces a
//     1-bit PDM stream for a pin-level RC DAC.
//
// Ports
//   nclk       in   1  system clock, rising-edge active
//   reset      in   1  synchronous, active-high reset
//   en         in   1  sample strobe; `in` is valid when en=1
//   in         in   8  unsigned mixer sample
//   pcm        out  8  averaged unsigned PCM sample
//   pcm_valid  out  1  pcm holds an unconsumed sample
//   pcm_ready  in   1  consumer takes pcm when pcm_valid & pcm_ready
//   overrun    out  1  sticky: a completed sample replaced an unconsumed one
//   pdm        out  1  delta-sigma bitstream, ones density = level/256
// ---------------------------------------------------------------------------
module apu_audio_dac #(
   parameter int DECIM_LOG2 = 5   // legal range 1..8
) (
   input  logic       nclk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] in,
   output logic [7:0] pcm,
   output logic       pcm_valid,
   input  logic       pcm_ready,
   output logic       overrun,
   output logic       pdm
);

   localparam int AW = 8 + DECIM_LOG2;
   localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;   // N-1

   logic [AW-1:0]         acc_q,   acc_d;
   logic [DECIM_LOG2-1:0] cnt_q,   cnt_d;
   logic [7:0]            level_q, level_d;
   logic [7:0]            sd_q,    sd_d;
   logic [7:0]            pcm_q,   pcm_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q,   ovr_d;
   logic                  pdm_q,   pdm_d;

   logic [AW-1:0] sum;
   logic [7:0]    avg;
   logic          done;
   logic [8:0]    mod_sum;

   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pcm_d   = pcm_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      // The sum of N 8-bit samples fits in 8+DECIM_LOG2 bits. Taking the top
      // 8 bits is the truncating divide by N.
      sum  = acc_q + {{DECIM_LOG2{1'b0}}, in};
      avg  = sum[AW-1:DECIM_LOG2];
      done = en && (cnt_q == CNT_LAST);

      if (en) begin
         if (done) begin
            acc_d   = '0;
            cnt_d   = '0;
            level_d = avg;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + DECIM_LOG2'(1);
         end
      end

      // One-entry output buffer. A completion takes priority over a plain
      // consume. A completion that coincides with a handshake is not an
      // overrun, because the old sample was taken in that same cycle.
      if (done) begin
         pcm_d   = avg;
         valid_d = 1'b1;
         if (valid_q && !pcm_ready) begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && pcm_ready) begin
         valid_d = 1'b0;
      end

      // First-order delta-sigma: the carry out of the error accumulator is
      // the output bit. Over 256 cycles at constant level L it carries
      // exactly L times.
      mod_sum = {1'b0, sd_q} + {1'b0, level_q};
      sd_d    = mod_sum[7:0];
      pdm_d   = mod_sum[8];
   end

   // NOTE: sequential state uses non-blocking assignments. Every flop then
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge nclk) begin
      if (reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         sd_q    <= '0;
         pcm_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         pdm_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         sd_q    <= sd_d;
         pcm_q   <= pcm_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         pdm_q   <= pdm_d;
      end
   end

   assign pcm       = pcm_q;
   assign pcm_valid = valid_q;
   assign overrun   = ovr_q;
   assign pdm       = pdm_q;

endmodule

// File: tb/tb_apu_audio_dac.sv
// ---------------------------------------------------------------------------
// tb_apu_audio_dac
//
// Self-checking bench for apu_audio_dac with DECIM_LOG2=2 (N=4).
//
// The reference model works at the level of whole blocks:
//   - it collects the strobed samples of the current block in a queue and
//     averages them when the queue holds N samples;
//   - it tracks the output buffer as "holding / empty";
//   - it predicts each PDM bit from the running total of all levels fed to
//     the modulator, as a change in floor(total/256).
// Directed steps cover the listed scenarios and use explicit constant
// expectations. A randomized tail then checks the model on every cycle.
// ---------------------------------------------------------------------------
module tb_apu_audio_dac;

   localparam int DL = 2;
   localparam int N  = 1 << DL;

   logic       nclk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] in;
   logic       pcm_ready;
   logic [7:0] pcm;
   logic       pcm_valid;
   logic       overrun;
   logic       pdm;

   apu_audio_dac #(.DECIM_LOG2(DL)) dut (
      .nclk      (nclk),
      .reset     (reset),
      .en        (en),
      .in        (in),
      .pcm       (pcm),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun),
      .pdm       (pdm)
   );

   always #5 nclk = ~nclk;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   int     blk[$];
   int     m_pcm   = 0;
   int     m_level = 0;
   bit     m_valid = 1'b0;
   bit     m_ovr   = 1'b0;
   bit     m_pdm   = 1'b0;
   longint m_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, and compare
   // all outputs #1 after the edge.
   task automatic step(input bit r, input bit e, input int d, input bit rdy);
      bit done;
      int s;
      reset     = r;
      en        = e;
      in        = d[7:0];
      pcm_ready = rdy;
      @(posedge nclk);
      if (r) begin
         blk.delete();
         m_pcm   = 0;
         m_level = 0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_pdm   = 1'b0;
         m_total = 0;
      end else begin
         // The modulator sees the level from before this edge.
         m_pdm   = ((m_total + m_level) / 256) != (m_total / 256);
         m_total = m_total + m_level;
         done = 1'b0;
         if (e) begin
            blk.push_back(d);
            if (blk.size() == N) begin
               done = 1'b1;
               s = blk.sum();
               if (m_valid && !rdy) m_ovr = 1'b1;
               m_pcm   = s / N;
               m_level = s / N;
               m_valid = 1'b1;
               blk.delete();
            end
         end
         if (!done && m_valid && rdy) m_valid = 1'b0;
      end
      #1;
      check("pcm",       32'(pcm),       32'(m_pcm));
      check("pcm_valid", 32'(pcm_valid), 32'(m_valid));
      check("overrun",   32'(overrun),   32'(m_ovr));
      check("pdm",       32'(pdm),       32'(m_pdm));
   endtask

   task automatic pdm_window(input string tag, input int exp_ones);
      int ones = 0;
      repeat (2) step(1'b0, 1'b0, 0, 1'b1);   // let the new level reach pdm
      repeat (256) begin
         step(1'b0, 1'b0, 0, 1'b1);
         ones += int'(pdm);
      end
      check(tag, 32'(ones), 32'(exp_ones));
   endtask

   initial begin
      int a0, a1, a2, a3;
      reset = 1'b1; en = 1'b0; in = '0; pcm_ready = 1'b0;

      // Reset after random activity.
      step(1'b1, 1'b0, 0, 1'b0);
      repeat (12) step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)));
      step(1'b1, 1'b1, 77, 1'b1);
      check("rst_pcm",   32'(pcm),       32'd0);
      check("rst_valid", 32'(pcm_valid), 32'd0);
      check("rst_ovr",   32'(overrun),   32'd0);
      check("rst_pdm",   32'(pdm),       32'd0);
      repeat (6) begin
         step(1'b0, 1'b0, 0, 1'b0);
         check("rst_pdm_idle", 32'(pdm), 32'd0);
      end

      // Continuous strobes, two blocks.
      step(1'b0, 1'b1, 0, 1'b1);
      step(1'b0, 1'b1, 1, 1'b1);
      step(1'b0, 1'b1, 2, 1'b1);
      step(1'b0, 1'b1, 5, 1'b1);
      check("blk1_pcm",   32'(pcm),       32'd2);
      check("blk1_valid", 32'(pcm_valid), 32'd1);
      step(1'b0, 1'b1, 3, 1'b1);
      step(1'b0, 1'b1, 3, 1'b1);
      step(1'b0, 1'b1, 3, 1'b1);
      step(1'b0, 1'b1, 4, 1'b1);
      check("blk2_pcm",   32'(pcm),       32'd3);
      check("blk2_valid", 32'(pcm_valid), 32'd1);
      check("blk2_ovr",   32'(overrun),   32'd0);

      // Sparse strobes: the idle cycles must not disturb acc/cnt.
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b1, 200, 1'b1);
         if (i != N - 1) repeat (2) step(1'b0, 1'b0, 13, 1'b1);
      end
      check("sparse_pcm",   32'(pcm),       32'd200);
      check("sparse_valid", 32'(pcm_valid), 32'd1);

      // A completion that coincides with a consume keeps valid and is not an overrun.
      step(1'b1, 1'b0, 0, 1'b0);
      repeat (N) step(1'b0, 1'b1, 40, 1'b0);
      step(1'b0, 1'b1, 80, 1'b0);
      step(1'b0, 1'b1, 80, 1'b0);
      step(1'b0, 1'b1, 80, 1'b0);
      step(1'b0, 1'b1, 81, 1'b1);
      check("cons_pcm",   32'(pcm),       32'd80);
      check("cons_valid", 32'(pcm_valid), 32'd1);
      check("cons_ovr",   32'(overrun),   32'd0);

      // Overrun: two blocks with the consumer stalled.
      step(1'b1, 1'b0, 0, 1'b0);
      repeat (N) step(1'b0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
      check("ovr_v1", 32'(pcm_valid), 32'd1);
      check("ovr_o1", 32'(overrun),   32'd0);
      a0 = int'($urandom_range(0, 255)); a1 = int'($urandom_range(0, 255));
      a2 = int'($urandom_range(0, 255)); a3 = int'($urandom_range(0, 255));
      step(1'b0, 1'b1, a0, 1'b0);
      step(1'b0, 1'b1, a1, 1'b0);
      step(1'b0, 1'b1, a2, 1'b0);
      step(1'b0, 1'b1, a3, 1'b0);
      check("ovr_pcm2", 32'(pcm),     32'((a0 + a1 + a2 + a3) / 4));
      check("ovr_o2",   32'(overrun), 32'd1);
      step(1'b0, 1'b0, 0, 1'b1);
      check("ovr_drain_valid", 32'(pcm_valid), 32'd0);
      check("ovr_sticky",      32'(overrun),   32'd1);

      // PDM density at constant levels.
      step(1'b1, 1'b0, 0, 1'b1);
      repeat (N) step(1'b0, 1'b1, 64, 1'b1);
      pdm_window("pdm_ones_64", 64);
      repeat (N) step(1'b0, 1'b1, 0, 1'b1);
      pdm_window("pdm_ones_0", 0);
      repeat (N) step(1'b0, 1'b1, 255, 1'b1);
      pdm_window("pdm_ones_255", 255);

      // Reset in mid-block discards the partial sum.
      step(1'b1, 1'b0, 0, 1'b1);
      step(1'b0, 1'b1, 255, 1'b1);
      step(1'b0, 1'b1, 255, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1);
      repeat (N) step(1'b0, 1'b1, 10, 1'b1);
      check("midrst_pcm",   32'(pcm),       32'd10);
      check("midrst_valid", 32'(pcm_valid), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 255)), 1'($urandom_range(0, 2) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apu_audio_dac.md
# apu_audio_dac

Audio output stage that sits directly downstream of the APU mixer. It consumes the mixer's 8-bit sample on every APU sample strobe and decimates by box-car averaging. It presents the averaged PCM sample on a ready/valid port for a codec/I2S serializer. It also drives a first-order delta-sigma 1-bit PDM output for a pin-level RC DAC.

## Interface
Parameters:
- DECIM_LOG2, default 5 — log2 of decimation ratio N (N = 2^DECIM_LOG2 input samples per PCM sample); legal range 1..8.

Ports:
- nclk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; `in` is valid in cycles where en=1.
- in  in  8  unsigned mixer sample.
- pcm  out  8  averaged unsigned PCM sample.
- pcm_valid  out  1  pcm holds an unconsumed sample.
- pcm_ready  in  1  consumer accepts pcm when pcm_valid & pcm_ready.
- overrun  out  1  sticky: a completed sample overwrote an unconsumed one.
- pdm  out  1  delta-sigma bitstream, density = level/256.

## Operation
- State:
  - acc, 8+DECIM_LOG2 bits, unsigned.
  - cnt, DECIM_LOG2 bits.
  - level, 8 bits: the last completed average, feeding the modulator.
  - sd, 8 bits: modulator error.
  - Output registers pcm, pcm_valid, overrun, pdm.
- Accumulate:
  - en=1 and cnt != N-1: acc <= acc + in; cnt <= cnt + 1.
  - en=0: acc and cnt hold; gaps between strobes of any length are legal.
- Block completion (en=1 and cnt == N-1):
  - avg = (acc + in) >> DECIM_LOG2, truncating. No rounding. The sum never overflows acc width.
  - acc <= 0; cnt <= 0; level <= avg.
- Output buffer (one entry):
  - On completion: pcm <= avg; pcm_valid <= 1.
  - If pcm_valid=1 and pcm_ready=0 in the completion cycle, the old sample is lost and overrun <= 1.
  - Without completion: pcm_valid & pcm_ready clears pcm_valid next cycle.
  - Completion and pcm_valid & pcm_ready in the same cycle: the old sample counts as consumed, the new one loads, pcm_valid stays 1, no overrun.
  - pcm is stable while pcm_valid=1 and not overwritten.
  - overrun clears only on reset.
- Modulator runs every nclk cycle, independent of en and of the handshake:
  - s = {1'b0, sd} + {1'b0, level} (9 bits).
  - sd <= s[7:0]; pdm <= s[8].
  - Over any 256 consecutive cycles with constant level L, exactly L ones are produced.

## Timing
- Reset (reset=1 at a clock edge): acc, cnt, level, sd, pcm, pcm_valid, overrun, pdm all become 0. Reset has priority over en and pcm_ready.
- A partially accumulated block is discarded on reset. The first post-reset block starts with the first en after reset deasserts.
- Latency: pcm and pcm_valid update at the edge that samples the N-th en, so they are visible the following cycle.
- level updates at that same edge. The modulator uses the new level from the next edge.
- pdm is registered, with no combinational path from any input.
- Throughput: one input per cycle (en held high) is supported, giving one PCM sample every N cycles.
- pcm_ready is ignored while pcm_valid=0.

## Test plan
- Reset: drive random inputs, then assert reset → pcm=0, pcm_valid=0, overrun=0, pdm=0 the next cycle, and pdm stays 0 with no en.
- DECIM_LOG2=2, en continuous, in=0,1,2,5 then 3,3,3,4, pcm_ready=1 → pcm=2 valid one cycle after the 4th strobe, then pcm=3 (13>>2); no overrun.
- DECIM_LOG2=2, en every 3rd cycle, in=200 constant → pcm=200 one cycle after the 4th strobe. acc/cnt are unaffected by en=0 cycles.
- Handshake, DECIM_LOG2=2, continuous en, pcm_ready=0 for two blocks:
  - First block → pcm_valid=1, overrun=0.
  - Second block → pcm = second average, overrun=1.
  - Then pcm_ready=1 → pcm_valid=0 next cycle; overrun remains 1.
  - Completion with pcm_ready=1 while valid → pcm_valid stays 1, overrun unchanged.
- PDM density: force level via a block of constant in=64 → exactly 64 ones per 256-cycle window. With in=0 → no ones; with in=255 → 255 ones.
- Reset mid-block, DECIM_LOG2=2: 2 strobes of in=255, reset, then 4 strobes of in=10 → pcm=10.
